// File: rtl/goertzel_sched.sv
// goertzel_sched: runs one Goertzel bin engine over up to NB bins of an NS-sample block
// Ports:
//    clk, rst                      clock, synchronous active-high reset
//    start, nbins_i                run request and bin count (clamped to NB)
//    busy, done, err               run in progress, end-of-run pulse, sticky timeout
//    coef_addr, coef_*_i           coefficient ROM address / data (1-cycle latency)
//    eng_alpha_o, eng_cw_*_o       coefficients held for the engine
//    smp_rd, smp_addr, smp_data_i  sample RAM read port (1-cycle latency)
//    eng_rstn, eng_en, eng_data_o  engine control and sample feed
//    eng_valid_i, eng_result_i     engine result
//    res_valid/ready/data/bin      result stream tagged with bin index
module goertzel_sched #(
   parameter int NS   = 1000,
   parameter int NB   = 16,
   parameter int TMO  = 64,
   parameter int RSTW = 2,
   parameter int AW   = $clog2(NS),
   parameter int BW   = $clog2(NB + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [BW-1:0] nbins_i,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [BW-1:0] coef_addr,
   input  logic [63:0]   coef_alpha_i,
   input  logic [63:0]   coef_re_i,
   input  logic [63:0]   coef_im_i,
   output logic [63:0]   eng_alpha_o,
   output logic [63:0]   eng_cw_re_o,
   output logic [63:0]   eng_cw_im_o,
   output logic          smp_rd,
   output logic [AW-1:0] smp_addr,
   input  logic [31:0]   smp_data_i,
   output logic          eng_rstn,
   output logic          eng_en,
   output logic [31:0]   eng_data_o,
   input  logic          eng_valid_i,
   input  logic [31:0]   eng_result_i,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [31:0]   res_data,
   output logic [BW-1:0] res_bin
);
   localparam int CW = $clog2(NS + TMO + RSTW + 1);
   typedef enum logic [2:0] {S_IDLE, S_ARM, S_FEED, S_WAIT, S_OUT, S_DONE} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [BW-1:0] r_bin, w_bin, r_nb, w_nb, r_res_bin;
   logic          r_err, w_err;
   logic [63:0]   r_alpha, r_re, r_im;
   logic [31:0]   r_res_data;
   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt + 1'b1;
      w_bin  = r_bin;
      w_nb   = r_nb;
      w_err  = r_err;
      case (r_state)
         S_IDLE: if (start) begin
            w_nb   = (nbins_i > BW'(NB)) ? BW'(NB) : nbins_i;
            w_err  = 1'b0;
            w_bin  = '0;
            w_cnt  = '0;
            w_next = (w_nb == '0) ? S_DONE : S_ARM;
         end
         S_ARM: if (r_cnt == CW'(RSTW - 1)) begin
            w_next = S_FEED;
            w_cnt  = '0;
         end
         // k runs 0..NS: reads at 0..NS-1, engine feed at 1..NS
         S_FEED: if (r_cnt == CW'(NS)) begin
            w_next = S_WAIT;
            w_cnt  = CW'(1);
         end
         // r_cnt counts cycles since the last eng_en, so err rises TMO cycles after it
         S_WAIT: if (eng_valid_i) w_next = S_OUT;
            else if (r_cnt == CW'(TMO - 1)) begin
               w_next = S_DONE;
               w_err  = 1'b1;
            end
         S_OUT: if (res_ready) begin
            w_bin  = r_bin + 1'b1;
            w_cnt  = '0;
            w_next = (w_bin == r_nb) ? S_DONE : S_ARM;
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bin      <= '0;
         r_nb       <= '0;
         r_err      <= 1'b0;
         r_alpha    <= '0;
         r_re       <= '0;
         r_im       <= '0;
         r_res_data <= '0;
         r_res_bin  <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_bin   <= w_bin;
         r_nb    <= w_nb;
         r_err   <= w_err;
         // ROM was addressed on the first ARM cycle, so its data is valid by the last
         if (r_state == S_ARM && r_cnt == CW'(RSTW - 1)) begin
            r_alpha <= coef_alpha_i;
            r_re    <= coef_re_i;
            r_im    <= coef_im_i;
         end
         if (r_state == S_WAIT && eng_valid_i) begin
            r_res_data <= eng_result_i;
            r_res_bin  <= r_bin;
         end
      end
   end
   assign busy        = r_state != S_IDLE;
   assign done        = r_state == S_DONE;
   assign err         = r_err;
   assign coef_addr   = r_bin;
   assign eng_alpha_o = r_alpha;
   assign eng_cw_re_o = r_re;
   assign eng_cw_im_o = r_im;
   assign smp_rd      = r_state == S_FEED && r_cnt < CW'(NS);
   assign smp_addr    = smp_rd ? AW'(r_cnt) : '0;
   assign eng_en      = r_state == S_FEED && r_cnt != '0;
   // smp_data_i is the RAM's registered output for address k-1
   assign eng_data_o  = eng_en ? smp_data_i : '0;
   assign eng_rstn    = r_state != S_IDLE && r_state != S_ARM;
   assign res_valid   = r_state == S_OUT;
   assign res_data    = r_res_data;
   assign res_bin     = r_res_bin;
endmodule
